// File: rtl/hash_word_packer_pkg.sv
// Shared constants and state type for the Keccak rate-block word packer.
package hash_word_packer_pkg;

    localparam int unsigned RATE_BITS       = 576;
    localparam int unsigned RATE_BYTES      = 72;
    localparam int unsigned WORD_W          = 64;
    localparam int unsigned WORDS_PER_BLOCK = 9;
    localparam int unsigned BYTE_CNT_W      = 10;

    typedef enum logic [1:0] {
        FILL,
        SEND,
        SEND_EMPTY
    } state_e;

endpackage

// File: rtl/word_byte_mask.sv
// Keeps the leading i_bytes bytes of a word (byte 0 in the MSBs); counts above 8 clamp to 8.
module word_byte_mask
    import hash_word_packer_pkg::*;
(
    input  logic [3:0]        i_bytes,
    output logic [3:0]        o_bytes,
    output logic [WORD_W-1:0] o_mask
);

    logic [3:0] w_bytes;

    always_comb begin
        w_bytes = (i_bytes > 4'd8) ? 4'd8 : i_bytes;
        o_mask  = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_bytes > 4'(i)) begin
                o_mask[WORD_W-1-8*i -: 8] = 8'hFF;
            end
        end
    end

    assign o_bytes = w_bytes;

endmodule

// File: rtl/hash_word_packer.sv
// Packs 64-bit message words into 576-bit rate blocks for the Keccak padder,
// flagging the final block with its valid byte count.
module hash_word_packer #(
    parameter int unsigned WORD_W     = 64,
    parameter int unsigned RATE_BYTES = 72
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WORD_W-1:0]       din,
    input  logic                    din_valid,
    input  logic                    din_last,
    input  logic [3:0]              din_bytes,
    output logic                    din_ready,
    output logic [RATE_BYTES*8-1:0] blk_out,
    output logic                    blk_valid,
    output logic                    blk_last,
    output logic [9:0]              blk_byte_num,
    input  logic                    buffer_full
);

    import hash_word_packer_pkg::*;

    localparam int unsigned          RATE_W       = RATE_BYTES * 8;
    localparam logic [9:0]           RATE_BYTES_C = 10'(RATE_BYTES);
    localparam logic [3:0]           LAST_SLOT    = 4'(WORDS_PER_BLOCK - 1);

    state_e              r_state, w_state_d;
    logic [3:0]          r_cnt, w_cnt_d;
    logic [RATE_W-1:0]   r_blk, w_blk_d;
    logic                r_valid, w_valid_d;
    logic                r_last, w_last_d;
    logic [9:0]          r_bn, w_bn_d;
    logic                r_pend, w_pend_d;

    logic [3:0]          w_bytes;
    logic [WORD_W-1:0]   w_mask;
    logic [WORD_W-1:0]   w_word;
    logic [9:0]          w_total;
    logic                w_accept;
    logic                w_xfer;

    word_byte_mask u_word_byte_mask (
        .i_bytes (din_bytes),
        .o_bytes (w_bytes),
        .o_mask  (w_mask)
    );

    assign w_word   = din_last ? (din & w_mask) : din;
    assign w_total  = {3'b000, r_cnt, 3'b000} + {6'b000000, w_bytes};
    assign w_accept = din_valid && (r_state == FILL);
    assign w_xfer   = r_valid && !buffer_full;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_blk_d   = r_blk;
        w_valid_d = r_valid;
        w_last_d  = r_last;
        w_bn_d    = r_bn;
        w_pend_d  = r_pend;

        case (r_state)
            FILL: begin
                if (w_accept) begin
                    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                        if (r_cnt == 4'(i)) begin
                            w_blk_d[RATE_W-1-WORD_W*i -: WORD_W] = w_word;
                        end
                    end
                    if (din_last) begin
                        w_state_d = SEND;
                        w_valid_d = 1'b1;
                        // An exactly full final block still needs a trailing empty last block.
                        if (w_total == RATE_BYTES_C) begin
                            w_last_d = 1'b0;
                            w_bn_d   = '0;
                            w_pend_d = 1'b1;
                        end else begin
                            w_last_d = 1'b1;
                            w_bn_d   = w_total;
                        end
                    end else if (r_cnt == LAST_SLOT) begin
                        w_state_d = SEND;
                        w_valid_d = 1'b1;
                        w_last_d  = 1'b0;
                        w_bn_d    = '0;
                    end else begin
                        w_cnt_d = r_cnt + 4'd1;
                    end
                end
            end
            SEND: begin
                if (w_xfer) begin
                    w_blk_d = '0;
                    w_cnt_d = '0;
                    if (r_pend) begin
                        w_state_d = SEND_EMPTY;
                        w_last_d  = 1'b1;
                        w_bn_d    = '0;
                        w_pend_d  = 1'b0;
                    end else begin
                        w_state_d = FILL;
                        w_valid_d = 1'b0;
                        w_last_d  = 1'b0;
                        w_bn_d    = '0;
                    end
                end
            end
            SEND_EMPTY: begin
                if (w_xfer) begin
                    w_state_d = FILL;
                    w_blk_d   = '0;
                    w_cnt_d   = '0;
                    w_valid_d = 1'b0;
                    w_last_d  = 1'b0;
                    w_bn_d    = '0;
                end
            end
            default: begin
                w_state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_blk   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_bn    <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_blk   <= w_blk_d;
            r_valid <= w_valid_d;
            r_last  <= w_last_d;
            r_bn    <= w_bn_d;
            r_pend  <= w_pend_d;
        end
    end

    assign din_ready    = (r_state == FILL);
    assign blk_out      = r_blk;
    assign blk_valid    = r_valid;
    assign blk_last     = r_last;
    assign blk_byte_num = r_bn;

endmodule

// File: tb/tb_hash_word_packer.sv
// Randomised bench for hash_word_packer: a byte-stream model predicts every block.
module tb_hash_word_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  din;
    logic         din_valid;
    logic         din_last;
    logic [3:0]   din_bytes;
    logic         din_ready;
    logic [575:0] blk_out;
    logic         blk_valid;
    logic         blk_last;
    logic [9:0]   blk_byte_num;
    logic         buffer_full = 1'b0;

    logic bf_force = 1'b0;
    logic bf_rand  = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [575:0] data;
        logic         last;
        logic [9:0]   bn;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] msg_words[$];

    hash_word_packer #(
        .WORD_W     (64),
        .RATE_BYTES (72)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .din_last     (din_last),
        .din_bytes    (din_bytes),
        .din_ready    (din_ready),
        .blk_out      (blk_out),
        .blk_valid    (blk_valid),
        .blk_last     (blk_last),
        .blk_byte_num (blk_byte_num),
        .buffer_full  (buffer_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Message as a flat byte stream, cut into 72-byte blocks; the block holding
    // the end of the stream is the last one (possibly empty).
    task automatic model_msg(input int braw);
        logic [7:0] bytes[$];
        int   n;
        int   nb;
        int   t;
        int   nblk;
        exp_t e;
        n = msg_words.size();
        for (int i = 0; i < n; i++) begin
            nb = (i == n - 1) ? ((braw > 8) ? 8 : braw) : 8;
            for (int k = 0; k < nb; k++) bytes.push_back(msg_words[i][63-8*k -: 8]);
        end
        t    = bytes.size();
        nblk = t / 72 + 1;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int j = 0; j < 72; j++) begin
                if (72 * b + j < t) e.data[575-8*j -: 8] = bytes[72*b+j];
            end
            e.last = (b == nblk - 1);
            e.bn   = e.last ? 10'(t - 72 * b) : 10'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_words(input bit with_last, input int braw, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < msg_words.size()) begin
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
            end else begin
                din_valid = 1'b1;
                din       = msg_words[i];
                din_last  = with_last && (i == msg_words.size() - 1);
                din_bytes = 4'(braw);
            end
            @(negedge clk);
            if (din_valid && din_ready) i++;
            guard++;
            if (guard > 5000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got %0d words, want %0d", i, msg_words.size());
                break;
            end
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || blk_valid) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: got %0d blocks pending, want 0", exp_q.size());
        end
    endtask

    task automatic rand_words(input int n);
        msg_words.delete();
        for (int i = 0; i < n; i++) msg_words.push_back({$urandom, $urandom});
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            buffer_full = bf_force | (bf_rand && ($urandom_range(0, 2) == 0));
        end
    end

    // Scoreboard: every transfer pops one expected block; presented blocks must hold while stalled.
    initial begin
        logic [575:0] p_out;
        logic         p_valid;
        logic         p_bf;
        logic         p_last;
        logic [9:0]   p_bn;
        exp_t         e;
        p_valid = 1'b0;
        p_bf    = 1'b0;
        p_last  = 1'b0;
        p_bn    = '0;
        p_out   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_valid = 1'b0;
            end else begin
                chk("din_ready_vs_valid", din_ready, !blk_valid);
                if (!blk_last) chk("byte_num_nonlast", blk_byte_num, 0);
                if (p_valid && p_bf) begin
                    chk("hold_valid", blk_valid, 1);
                    chk("hold_out", blk_out, p_out);
                    chk("hold_last", blk_last, p_last);
                    chk("hold_bn", blk_byte_num, p_bn);
                end
                if (blk_valid && !buffer_full) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_block: got %0h, want none", blk_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_out", blk_out, e.data);
                        chk("blk_last", blk_last, e.last);
                        chk("blk_byte_num", blk_byte_num, e.bn);
                    end
                end
                p_valid = blk_valid;
                p_bf    = buffer_full;
                p_out   = blk_out;
                p_last  = blk_last;
                p_bn    = blk_byte_num;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [575:0] lit;
        logic [63:0]  w;
        int           cnt;
        int           guard;

        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        din_last  = 1'b0;
        din_bytes = '0;
        @(negedge clk);
        chk("reset_valid", blk_valid, 0);
        chk("reset_out", blk_out, 0);
        chk("reset_last", blk_last, 0);
        chk("reset_bn", blk_byte_num, 0);
        chk("reset_ready", din_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single 1-byte last word, checked for one-cycle latency.
        w = 64'h90AB_CDEF_1111_1111;
        msg_words.delete();
        msg_words.push_back(w);
        model_msg(1);
        lit = '0;
        lit[575:568] = 8'h90;
        chk("pin_t1_data", exp_q[0].data, lit);
        chk("pin_t1_bn", exp_q[0].bn, 1);
        drive_words(1, 1, 0);
        @(negedge clk);
        chk("t1_latency_valid", blk_valid, 1);
        chk("t1_data", blk_out, lit);
        chk("t1_last", blk_last, 1);
        chk("t1_bn", blk_byte_num, 1);
        wait_drain();

        // Nine full words: full non-last block then empty last block.
        msg_words.delete();
        for (int i = 0; i < 9; i++) msg_words.push_back(w);
        model_msg(8);
        chk("pin_t2_blk0", exp_q[0].data, {9{w}});
        chk("pin_t2_blk0_last", exp_q[0].last, 0);
        chk("pin_t2_blk1", exp_q[1].data, 0);
        chk("pin_t2_blk1_last", exp_q[1].last, 1);
        chk("pin_t2_blk1_bn", exp_q[1].bn, 0);
        drive_words(1, 8, 0);
        wait_drain();

        // Ten full words.
        rand_words(10);
        model_msg(8);
        lit = '0;
        lit[575:512] = msg_words[9];
        chk("pin_t3_blk1", exp_q[1].data, lit);
        chk("pin_t3_blk1_bn", exp_q[1].bn, 8);
        drive_words(1, 8, 1);
        wait_drain();

        // Stall a presented block for five cycles.
        rand_words(1);
        model_msg(8);
        bf_force = 1'b1;
        drive_words(1, 8, 0);
        cnt   = 0;
        guard = 0;
        do begin
            @(negedge clk);
            if (blk_valid) cnt++;
            if (cnt == 5) bf_force = 1'b0;
            guard++;
        end while ((blk_valid || cnt == 0) && guard < 50);
        bf_force = 1'b0;
        chk("t4_valid_cycles", cnt, 6);
        wait_drain();

        // Empty message, then an over-range byte count.
        rand_words(1);
        model_msg(0);
        chk("pin_t5_empty", exp_q[0].data, 0);
        chk("pin_t5_empty_bn", exp_q[0].bn, 0);
        drive_words(1, 0, 0);
        wait_drain();
        rand_words(1);
        model_msg(12);
        chk("pin_t5_clamp_bn", exp_q[0].bn, 8);
        drive_words(1, 12, 0);
        wait_drain();

        // Reset after four accepted words discards the partial block.
        rand_words(4);
        drive_words(0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_reset_valid", blk_valid, 0);
        chk("t6_reset_out", blk_out, 0);
        chk("t6_reset_last", blk_last, 0);
        chk("t6_reset_bn", blk_byte_num, 0);
        chk("t6_reset_ready", din_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        msg_words.delete();
        msg_words.push_back(w);
        model_msg(1);
        drive_words(1, 1, 0);
        wait_drain();

        // Randomised messages with gaps and random back-pressure.
        bf_rand = 1'b1;
        for (int m = 0; m < 40; m++) begin
            cnt = $urandom_range(1, 20);
            if (m % 10 == 3) cnt = 9;
            if (m % 10 == 7) cnt = 18;
            rand_words(cnt);
            guard = (m % 10 == 3 || m % 10 == 7) ? 8 : $urandom_range(0, 15);
            model_msg(guard);
            drive_words(1, guard, 1);
        end
        wait_drain();
        bf_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hash_word_packer.md
# hash_word_packer

Upstream feeder for the 576-bit-rate Keccak padder (`padder`). Collects a message arriving as 64-bit words with a valid/ready handshake. Packs nine words into one 576-bit rate block. Presents each block to the padder's `in` / `in_ready` / `is_last` / `byte_num` / `buffer_full` interface, and marks the final partial block with its byte count so the padder can append the padding.

## Interface
Parameters:
- `WORD_W`, default 64: input word width in bits; fixed, 64 only.
- `RATE_BYTES`, default 72: block size in bytes (576 bits); fixed.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `din`, in, 64: message word; byte 0 of the word is `din[63:56]`.
- `din_valid`, in, 1: `din` is valid.
- `din_last`, in, 1: this word is the last word of the message.
- `din_bytes`, in, 4: number of valid bytes in a `din_last` word, counted from `din[63:56]`. Legal range 0..8; values >8 are treated as 8. Ignored when `din_last`=0.
- `din_ready`, out, 1: packer accepts a word this cycle.
- `blk_out`, out, 576: block to the padder (`in`). The first word of the block is in `[575:512]`. Unused bytes are 0.
- `blk_valid`, out, 1: block is presented (`in_ready`).
- `blk_last`, out, 1: block is the final block of the message (`is_last`).
- `blk_byte_num`, out, 10: valid bytes in a last block, 0..71 (`byte_num`). It is 0 when `blk_last`=0.
- `buffer_full`, in, 1: the padder cannot take a block.

## Operation
- States:
  - FILL: accepting words.
  - SEND: presenting the packed block.
  - SEND_EMPTY: presenting an all-zero last block.
- Word counter `cnt` (4 bits, 0..8) gives the slot of the next word. A word is written to `blk_out[575-64*cnt -: 64]`. In a last word, bytes beyond `din_bytes` are zeroed.
- Accept condition: `din_valid && din_ready`. `din_ready` = (state==FILL).
- On accept in FILL:
  - If `din_last` and `cnt*8+din_bytes` < 72: go to SEND with `blk_last`=1 and `blk_byte_num`=`cnt*8+din_bytes`.
  - If `din_last` and the byte total = 72 (cnt=8, 8 bytes): go to SEND with `blk_last`=0. Then go to SEND_EMPTY, which sends a zero block with `blk_last`=1 and `blk_byte_num`=0.
  - Else if `cnt`=8: go to SEND with `blk_last`=0.
  - Else: `cnt` increments and the state stays FILL.
- Transfer rule: a block transfers on a cycle where `blk_valid` && !`buffer_full`. Until then `blk_valid`, `blk_out`, `blk_last` and `blk_byte_num` are held stable.
- After a transfer from SEND:
  - Go to SEND_EMPTY if it is pending.
  - Otherwise go to FILL, with `cnt`=0 and `blk_out` cleared to 0.
- After a transfer from SEND_EMPTY: go to FILL, with `cnt`=0 and `blk_out` cleared to 0.
- An empty message (`din_last` with `din_bytes`=0 at `cnt`=0) produces one last block with `blk_byte_num`=0.
- A `din_last` word whose bytes would exceed 72 cannot occur: at `cnt`=8 the maximum is 8 bytes, which gives exactly 72.

## Timing
- Reset values: state FILL, `cnt`=0, `blk_out`=0, `blk_valid`=0, `blk_last`=0, `blk_byte_num`=0, `din_ready`=1 (combinational from state).
- Latency:
  - `blk_valid` rises in the cycle after the clock edge that accepts the completing word.
  - The earliest transfer is in that same cycle.
  - `din_ready` returns 1 in the cycle after the final transfer.
- Throughput: 9 accept cycles plus at least 1 send cycle per block. Words are never accepted while a block is presented.
- `buffer_full` high while presenting: hold the block indefinitely, with no data change.
- `buffer_full` in FILL: ignored.
- Reset asserted mid-fill or mid-send: immediate return to reset values. A partial block is discarded and no block is emitted.
- `blk_valid` is registered; there is no combinational path from `buffer_full` to `blk_valid`.

## Structure
- Shared hash package holds:
  - `RATE_BITS`=576, `RATE_BYTES`=72, `WORD_W`=64, `WORDS_PER_BLOCK`=9.
  - The byte-count width (10).
  - A state enum {FILL, SEND, SEND_EMPTY}.
- One natural sub-module, `word_byte_mask`: a combinational 64-bit mask from `din_bytes` (0..8, clamped). Everything else stays in one file.

## Test plan
- Single last word `din`=0x90ABCDEF11111111, `din_bytes`=1 -> one block with `blk_out[575:568]`=0x90 and all other bits 0, `blk_last`=1, `blk_byte_num`=1, valid in the cycle after accept.
- Nine words of 0x90ABCDEF11111111, the ninth with `din_last` and `din_bytes`=8 -> block 1 = 9 copies, `blk_last`=0. Then block 2 = all zero, `blk_last`=1, `blk_byte_num`=0.
- Ten full words, the tenth with `din_last` and `din_bytes`=8 -> block 1 full, `blk_last`=0. Block 2 has word 10 in `[575:512]` and zeros elsewhere, `blk_last`=1, `blk_byte_num`=8.
- `buffer_full`=1 for 5 cycles while a block is presented -> `blk_valid` held 6 cycles, `blk_out` unchanged, `din_ready`=0 throughout, single transfer when `buffer_full` drops.
- Empty message (`din_last`, `din_bytes`=0, `cnt`=0) -> one zero block, `blk_last`=1, `blk_byte_num`=0. Also `din_bytes`=12 on a first word -> treated as 8, `blk_byte_num`=8.
- Reset pulse after 4 accepted words -> all outputs at reset values, no block emitted. A following 1-byte message yields `blk_byte_num`=1 with only that byte nonzero.
